// File: rtl/mul_wb.sv
// Sequential 32-cycle shift-add multiplier with signed/unsigned operands and
// a one-cycle register-file write-back of the selected product half.
module mul_wb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_signed,
  input  logic                  req_high,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [ADDR_WIDTH-1:0] req_rd,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy
);

  localparam int unsigned AccW = 2 * DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StWb} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    signed_q, signed_d;
  logic                    neg_q, neg_d;
  logic                    high_q, high_d;
  logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic [AccW-1:0]         addend, sum, res;

  // Operands are stored as magnitudes; the sign is reapplied on the full product.
  assign a_mag  = (req_signed && req_a[DATA_WIDTH-1]) ? -req_a : req_a;
  assign b_mag  = (req_signed && req_b[DATA_WIDTH-1]) ? -req_b : req_b;
  assign addend = b_q[cnt_q[CntW-2:0]] ? ({{DATA_WIDTH{1'b0}}, a_q} << cnt_q) : '0;
  assign sum    = acc_q + addend;
  assign res    = (signed_q && neg_q) ? -sum : sum;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    neg_d    = neg_q;
    high_d   = high_q;
    rd_d     = rd_q;
    wen_d    = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d      = a_mag;
          b_d      = b_mag;
          signed_d = req_signed;
          neg_d    = req_signed & (req_a[DATA_WIDTH-1] ^ req_b[DATA_WIDTH-1]);
          high_d   = req_high;
          rd_d     = req_rd;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StWb;
          wen_d   = (rd_q != '0);
          waddr_d = rd_q;
          wdata_d = high_q ? res[AccW-1 -: DATA_WIDTH] : res[DATA_WIDTH-1:0];
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      high_q   <= 1'b0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      neg_q    <= neg_d;
      high_q   <= high_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_mul_wb.sv
// Scoreboard bench for mul_wb: driver pushes expected write-backs, a negedge
// monitor checks handshake, busy window and write port every cycle.
module tb_mul_wb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_signed = 1'b0;
  logic          req_high = 1'b0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic [AW-1:0] req_rd = '0;
  logic          req_ready, wen, busy;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  mul_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_signed(req_signed),
    .req_high  (req_high),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            wb_cyc;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_t0 = -1000;

  // Reference: full-width product by plain arithmetic, then pick a half.
  function automatic logic [DW-1:0] model(input logic s, input logic h,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        p;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      p  = sa * sb;
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return h ? p[63:32] : p[31:0];
  endfunction

  // Monitor: every cycle the whole observable state is compared to expectation.
  always @(negedge clk) begin
    exp_t          e;
    logic          x_ready, x_busy, x_wen;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;
    x_busy  = rst_n && (cyc >= last_t0) && (cyc <= last_t0 + 32);
    x_ready = !x_busy;
    x_wen   = 1'b0;
    x_addr  = '0;
    x_data  = '0;
    if (sbq.size() > 0 && sbq[0].wb_cyc == cyc) begin
      e      = sbq.pop_front();
      x_wen  = (e.rd != '0);
      x_addr = e.rd;
      x_data = e.data;
    end
    n_tests++;
    if ({req_ready, busy, wen, waddr, wdata} !== {x_ready, x_busy, x_wen, x_addr, x_data}) begin
      n_fail++;
      $display("FAIL cycle %0d: got ready=%b busy=%b wen=%b waddr=%0d wdata=%h, want ready=%b busy=%b wen=%b waddr=%0d wdata=%h",
               cyc, req_ready, busy, wen, waddr, wdata, x_ready, x_busy, x_wen, x_addr, x_data);
    end
  end

  task automatic scramble(input bit hold);
    req_valid  = hold;
    req_a      = $urandom;
    req_b      = $urandom;
    req_rd     = AW'($urandom);
    req_signed = 1'($urandom);
    req_high   = 1'($urandom);
  endtask

  task automatic send(input logic s, input logic h, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [AW-1:0] rd,
                      input logic [DW-1:0] exp_data, input bit hold, input bit chk_gap);
    int t0;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        req_valid  = 1'b1;
        req_signed = s;
        req_high   = h;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
        got        = 1'b1;
        break;
      end
      scramble(hold);
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no ready in 100 cycles, want ready");
      return;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    if (chk_gap) begin
      n_tests++;
      if (t0 - last_t0 != 34) begin
        n_fail++;
        $display("FAIL accept_gap: got %0d cycles, want 34", t0 - last_t0);
      end
    end
    last_t0 = t0;
    sbq.push_back('{t0 + 32, rd, exp_data});
    scramble(hold);
  endtask

  task automatic send_rand(input bit hold, input bit chk_gap);
    logic          s, h;
    logic [DW-1:0] a, b;
    logic [AW-1:0] rd;
    s  = 1'($urandom);
    h  = 1'($urandom);
    a  = $urandom;
    b  = $urandom;
    rd = AW'($urandom);
    case ($urandom_range(0, 5))
      0: a = 32'h8000_0000;
      1: b = 32'hFFFF_FFFF;
      2: a = 32'h0;
      default: ;
    endcase
    send(s, h, a, b, rd, model(s, h, a, b), hold, chk_gap);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: got no finish, want finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, busy, wen, waddr, wdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b busy=%b wen=%b waddr=%0d wdata=%h, want 1 0 0 0 0",
               req_ready, busy, wen, waddr, wdata);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed corner cases with hand-computed results.
    send(1'b0, 1'b0, 32'd3, 32'd5, 5'd7, 32'd15, 1'b0, 1'b0);
    send(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b0, 1'b0);
    send(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 1'b0, 1'b0);
    send(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd6, 5'd4, 32'hFFFF_FFD6, 1'b0, 1'b0);
    send(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd6, 5'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b0, 1'b0);
    send(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, 1'b0, 1'b0);
    send(1'b0, 1'b0, 32'd9, 32'd9, 5'd0, 32'd81, 1'b0, 1'b0);

    // Back-to-back with valid held and operands churning between accepts.
    send_rand(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send_rand(1'b1, 1'b1);
    req_valid = 1'b0;

    for (int i = 0; i < 20; i++) send_rand(1'b0, 1'b0);

    // Abort mid-CALC: the pending write must never appear.
    send(1'b0, 1'b0, 32'd1234, 32'd5678, 5'd9, 32'd7006652, 1'b0, 1'b0);
    while (cyc < last_t0 + 10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, busy, wen} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset: got ready=%b busy=%b wen=%b, want 1 0 0", req_ready, busy, wen);
    end
    sbq.delete();
    last_t0 = -1000;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    send_rand(1'b0, 1'b0);
    send(1'b0, 1'b0, 32'd3, 32'd5, 5'd7, 32'd15, 1'b0, 1'b0);
    repeat (40) @(negedge clk);

    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending write-backs, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
